// File: rtl/lbist_ora.sv
// -----------------------------------------------------------------------------
// lbist_ora -- output response analyzer for the logic BIST.
//
// Each capture cycle the core response is space-compacted by XOR folding
// onto SIG_W bits. The folded word is then accumulated in a Galois MISR over
// N_PATTERNS captures. The final signature is compared with GOLDEN, and the
// result is held in pass.
//
// Ports:
//   clk        in   rising-edge clock, shared with the pattern generator
//   rst        in   asynchronous, active-high reset
//   start      in   one-cycle pulse that starts a session (ignored in RUN)
//   en         in   capture qualifier (pattern generator advance)
//   din        in   DIN_W core response (PO bits low, scan outputs high)
//   busy       out  session in progress
//   done       out  session complete (level)
//   pass       out  final signature matched GOLDEN (valid while done=1)
//   signature  out  current MISR contents
//   count      out  number of captures taken in this session
// -----------------------------------------------------------------------------
module lbist_ora #(
    parameter int                DIN_W      = 267,
    parameter int                SIG_W      = 32,
    parameter logic [SIG_W-1:0]  POLY       = 32'h04C11DB7,
    parameter logic [SIG_W-1:0]  SEED       = '0,
    parameter int                N_PATTERNS = 1024,
    parameter logic [SIG_W-1:0]  GOLDEN     = '0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                en,
    input  logic [DIN_W-1:0]                    din,
    output logic                                busy,
    output logic                                done,
    output logic                                pass,
    output logic [SIG_W-1:0]                    signature,
    output logic [$clog2(N_PATTERNS+1)-1:0]     count
);

    localparam int CNT_W = $clog2(N_PATTERNS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_PATTERNS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pass_q, pass_d;

    logic [SIG_W-1:0]   fold_s;
    logic [SIG_W-1:0]   misr_next_s;
    logic               capture_s;
    logic               last_s;

    // XOR-fold the response: bit k lands on signature bit k mod SIG_W.
    function automatic logic [SIG_W-1:0] fold_f(input logic [DIN_W-1:0] d);
        logic [SIG_W-1:0] f;
        f = '0;
        for (int j = 0; j < SIG_W; j++) begin
            for (int k = j; k < DIN_W; k += SIG_W) begin
                f[j] = f[j] ^ d[k];
            end
        end
        return f;
    endfunction

    // One Galois MISR step. The MSB feeds back into bit 0 unconditionally
    // and into every tap bit i where POLY[i]=1. POLY[0] is not used.
    function automatic logic [SIG_W-1:0] misr_f(input logic [SIG_W-1:0] s,
                                                input logic [SIG_W-1:0] f);
        logic [SIG_W-1:0] n;
        logic             m;
        m    = s[SIG_W-1];
        n[0] = m ^ f[0];
        for (int i = 1; i < SIG_W; i++) begin
            n[i] = s[i-1] ^ f[i] ^ (POLY[i] & m);
        end
        return n;
    endfunction

    assign fold_s      = fold_f(din);
    assign misr_next_s = misr_f(sig_q, fold_s);
    assign capture_s   = (state_q == S_RUN) && en;
    assign last_s      = capture_s && (cnt_q == CNT_LAST);

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath next values. start has priority over en outside RUN, so a
    // start cycle never captures. pass is settled on the capture that
    // completes the session, from the signature being registered there.
    always_comb begin
        sig_d  = sig_q;
        cnt_d  = cnt_q;
        pass_d = pass_q;
        if ((state_q != S_RUN) && start) begin
            sig_d  = SEED;
            cnt_d  = '0;
            pass_d = 1'b0;
        end else if (capture_s) begin
            sig_d  = misr_next_s;
            cnt_d  = cnt_q + CNT_W'(1);
            if (last_s) begin
                pass_d = (misr_next_s == GOLDEN);
            end else begin
                pass_d = pass_q;
            end
        end else begin
            sig_d  = sig_q;
            cnt_d  = cnt_q;
            pass_d = pass_q;
        end
    end

    // Outputs, decoded from registered state only.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                done = 1'b0;
            end
            S_RUN: begin
                busy = 1'b1;
                done = 1'b0;
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
        pass      = pass_q;
        signature = sig_q;
        count     = cnt_q;
    end

endmodule

// File: tb/tb_lbist_ora.sv
// -----------------------------------------------------------------------------
// Testbench for lbist_ora. It drives three instances:
//   A: SIG_W=4, DIN_W=8, POLY=3, SEED=0, GOLDEN=3, N=2 (directed sessions)
//   B: same, but SEED=8 and N=1 (MSB feedback path)
//   C: SIG_W=5, DIN_W=20, POLY=5, SEED=0xA, GOLDEN=0x13, N=7 (random
//      stimulus against a reference model)
// -----------------------------------------------------------------------------
module tb_lbist_ora;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    // ---------------- instance A ----------------
    logic       a_rst, a_start, a_en;
    logic [7:0] a_din;
    logic       a_busy, a_done, a_pass;
    logic [3:0] a_sig;
    logic [1:0] a_cnt;

    lbist_ora #(.DIN_W(8), .SIG_W(4), .POLY(4'h3), .SEED(4'h0),
                .N_PATTERNS(2), .GOLDEN(4'h3)) dut_a (
        .clk(clk), .rst(a_rst), .start(a_start), .en(a_en), .din(a_din),
        .busy(a_busy), .done(a_done), .pass(a_pass),
        .signature(a_sig), .count(a_cnt));

    // ---------------- instance B ----------------
    logic       b_rst, b_start, b_en;
    logic [7:0] b_din;
    logic       b_busy, b_done, b_pass;
    logic [3:0] b_sig;
    logic [0:0] b_cnt;

    lbist_ora #(.DIN_W(8), .SIG_W(4), .POLY(4'h3), .SEED(4'h8),
                .N_PATTERNS(1), .GOLDEN(4'h3)) dut_b (
        .clk(clk), .rst(b_rst), .start(b_start), .en(b_en), .din(b_din),
        .busy(b_busy), .done(b_done), .pass(b_pass),
        .signature(b_sig), .count(b_cnt));

    // ---------------- instance C ----------------
    localparam int C_SW   = 5;
    localparam int C_DW   = 20;
    localparam int C_POLY = 5;
    localparam int C_SEED = 10;
    localparam int C_N    = 7;
    localparam int C_GOLD = 19;

    logic        c_rst, c_start, c_en;
    logic [19:0] c_din;
    logic        c_busy, c_done, c_pass;
    logic [4:0]  c_sig;
    logic [2:0]  c_cnt;

    lbist_ora #(.DIN_W(C_DW), .SIG_W(C_SW), .POLY(5'h05), .SEED(5'h0A),
                .N_PATTERNS(C_N), .GOLDEN(5'h13)) dut_c (
        .clk(clk), .rst(c_rst), .start(c_start), .en(c_en), .din(c_din),
        .busy(c_busy), .done(c_done), .pass(c_pass),
        .signature(c_sig), .count(c_cnt));

    // Single comparison point for the whole bench.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic a_cyc(input logic st, input logic e, input logic [7:0] d);
        a_start = st; a_en = e; a_din = d;
        @(posedge clk); #1;
    endtask

    task automatic b_cyc(input logic st, input logic e, input logic [7:0] d);
        b_start = st; b_en = e; b_din = d;
        @(posedge clk); #1;
    endtask

    // ---------------- reference model for C ----------------
    // Session phase is kept as plain flags and the signature as an integer.
    int m_sig, m_cnt;
    bit m_act, m_fin, m_pass;

    // Fold as integer arithmetic: bit k contributes 2^(k mod SIG_W).
    function automatic int fold_ref(input logic [19:0] d);
        int f = 0;
        for (int k = 0; k < C_DW; k++) begin
            if (d[k]) f = f ^ (1 << (k % C_SW));
        end
        return f;
    endfunction

    // Multiply by x modulo the feedback polynomial (x^SIG_W = POLY|1), add fold.
    function automatic int step_ref(input int s, input int f);
        int t = s << 1;
        if (t >= (1 << C_SW)) t = (t ^ (C_POLY | 1)) & ((1 << C_SW) - 1);
        return t ^ f;
    endfunction

    task automatic m_reset();
        m_sig = C_SEED; m_cnt = 0; m_act = 0; m_fin = 0; m_pass = 0;
    endtask

    task automatic m_edge(input bit st, input bit e, input logic [19:0] d);
        if (!m_act) begin
            if (st) begin
                m_sig = C_SEED; m_cnt = 0; m_act = 1; m_fin = 0; m_pass = 0;
            end
        end else if (e) begin
            m_sig = step_ref(m_sig, fold_ref(d));
            m_cnt++;
            if (m_cnt == C_N) begin
                m_act = 0; m_fin = 1; m_pass = (m_sig == C_GOLD);
            end
        end
    endtask

    task automatic c_check(input string ph);
        chk({ph, "_busy"},  32'(c_busy), 32'(m_act));
        chk({ph, "_done"},  32'(c_done), 32'(m_fin));
        chk({ph, "_sig"},   32'(c_sig),  32'(m_sig));
        chk({ph, "_count"}, 32'(c_cnt),  32'(m_cnt));
        if (m_fin) chk({ph, "_pass"}, 32'(c_pass), 32'(m_pass));
    endtask

    initial begin
        a_rst = 1'b1; a_start = 1'b0; a_en = 1'b0; a_din = 8'h00;
        b_rst = 1'b1; b_start = 1'b0; b_en = 1'b0; b_din = 8'h00;
        c_rst = 1'b1; c_start = 1'b0; c_en = 1'b0; c_din = 20'h0;
        m_reset();
        #3;
        chk("rst_busy",  32'(a_busy), 32'd0);
        chk("rst_done",  32'(a_done), 32'd0);
        chk("rst_pass",  32'(a_pass), 32'd0);
        chk("rst_sig",   32'(a_sig),  32'd0);
        chk("rst_count", 32'(a_cnt),  32'd0);
        chk("rst_sig_b", 32'(b_sig),  32'd8);
        c_check("rst_c");
        #9;
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        @(posedge clk); #1;

        // start together with en in IDLE: start wins, nothing captured
        a_cyc(1'b1, 1'b1, 8'hFF);
        chk("idle_st_en_busy",  32'(a_busy), 32'd1);
        chk("idle_st_en_sig",   32'(a_sig),  32'd0);
        chk("idle_st_en_count", 32'(a_cnt),  32'd0);

        // basic session
        a_cyc(1'b0, 1'b1, 8'h01);
        chk("basic_sig1",   32'(a_sig),  32'h1);
        chk("basic_count1", 32'(a_cnt),  32'd1);
        chk("basic_busy1",  32'(a_busy), 32'd1);
        chk("basic_done1",  32'(a_done), 32'd0);
        a_cyc(1'b0, 1'b1, 8'h10);
        chk("basic_sig2",   32'(a_sig),  32'h3);
        chk("basic_count2", 32'(a_cnt),  32'd2);
        chk("basic_done2",  32'(a_done), 32'd1);
        chk("basic_pass2",  32'(a_pass), 32'd1);
        chk("basic_busy2",  32'(a_busy), 32'd0);

        // en in DONE is ignored
        a_cyc(1'b0, 1'b1, 8'h5A);
        chk("done_hold_sig",   32'(a_sig), 32'h3);
        chk("done_hold_count", 32'(a_cnt), 32'd2);

        // restart from DONE (start+en together: no capture)
        a_cyc(1'b1, 1'b1, 8'hFF);
        chk("restart_done", 32'(a_done), 32'd0);
        chk("restart_pass", 32'(a_pass), 32'd0);
        chk("restart_busy", 32'(a_busy), 32'd1);
        chk("restart_sig",  32'(a_sig),  32'h0);
        chk("restart_cnt",  32'(a_cnt),  32'd0);
        a_cyc(1'b0, 1'b1, 8'h01);
        // start during RUN is ignored
        a_cyc(1'b1, 1'b0, 8'h00);
        chk("run_start_sig", 32'(a_sig), 32'h1);
        chk("run_start_cnt", 32'(a_cnt), 32'd1);
        // stall
        for (int i = 0; i < 5; i++) begin
            a_cyc(1'b0, 1'b0, 8'($urandom));
            chk("stall_count", 32'(a_cnt), 32'd1);
            chk("stall_sig",   32'(a_sig), 32'h1);
        end
        a_cyc(1'b0, 1'b1, 8'h10);
        chk("stall_sig_final", 32'(a_sig),  32'h3);
        chk("stall_done",      32'(a_done), 32'd1);
        chk("stall_pass",      32'(a_pass), 32'd1);

        // fold aliasing
        a_cyc(1'b1, 1'b0, 8'h00);
        a_cyc(1'b0, 1'b1, 8'h11);
        chk("alias_sig1", 32'(a_sig), 32'h0);
        a_cyc(1'b0, 1'b1, 8'h00);
        chk("alias_sig2", 32'(a_sig),  32'h0);
        chk("alias_done", 32'(a_done), 32'd1);
        chk("alias_pass", 32'(a_pass), 32'd0);

        // asynchronous reset mid-RUN
        a_cyc(1'b1, 1'b0, 8'h00);
        a_cyc(1'b0, 1'b1, 8'h01);
        chk("pre_rst_sig", 32'(a_sig), 32'h1);
        #2; a_rst = 1'b1; #1;
        chk("async_busy",  32'(a_busy), 32'd0);
        chk("async_done",  32'(a_done), 32'd0);
        chk("async_sig",   32'(a_sig),  32'h0);
        chk("async_count", 32'(a_cnt),  32'd0);
        a_rst = 1'b0;
        a_cyc(1'b0, 1'b1, 8'h01);
        chk("post_rst_busy",  32'(a_busy), 32'd0);
        chk("post_rst_sig",   32'(a_sig),  32'h0);
        chk("post_rst_count", 32'(a_cnt),  32'd0);

        // feedback path on B
        b_cyc(1'b1, 1'b0, 8'h00);
        chk("fb_seed", 32'(b_sig), 32'h8);
        b_cyc(1'b0, 1'b1, 8'h00);
        chk("fb_sig",   32'(b_sig),  32'h3);
        chk("fb_done",  32'(b_done), 32'd1);
        chk("fb_count", 32'(b_cnt),  32'd1);
        chk("fb_pass",  32'(b_pass), 32'd1);

        // randomized sessions on C against the model
        for (int n = 0; n < 600; n++) begin
            bit          st, e;
            logic [19:0] d;
            if ($urandom_range(0, 99) < 2) begin
                c_rst = 1'b1; #1;
                m_reset();
                c_check("c_async");
                c_rst = 1'b0;
            end
            st = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 3) != 0);
            d  = 20'($urandom);
            c_start = st; c_en = e; c_din = d;
            m_edge(st, e, d);
            @(posedge clk); #1;
            c_check("c_rand");
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/lbist_ora.md
Name: lbist_ora

Overview:
- Output response analyzer for the RI5CY logic BIST. It is the receiving end of the test pattern generator.
- Each enabled cycle it captures the core's primary outputs and scan-chain outputs and space-compacts them by XOR folding.
- The folded word is accumulated in a Galois MISR over a fixed number of patterns, and the final signature is compared against a golden value.
- It sits beside the pattern generator and shares its clk and enable timing. The LBIST controller reads done/pass from it.

Parameters:
- DIN_W, 267, response width: 260 primary outputs plus 7 scan-chain outputs.
- SIG_W, 32, MISR/signature width (>=2).
- POLY, 32'h04C11DB7, feedback polynomial. Bit i is the coefficient of x^i for i=1..SIG_W-1; bit 0 is ignored (x^0 term is always 1).
- SEED, 0, MISR value loaded on reset and on start.
- N_PATTERNS, 1024, number of enabled capture cycles per session (>=1).
- GOLDEN, 0, expected final signature.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  one-cycle pulse that starts a session.
- en  in  1  capture qualifier, asserted in the same cycles the pattern generator advances.
- din  in  DIN_W  core response (PO bits first, scan outputs in the top 7 bits).
- busy  out  1  session in progress.
- done  out  1  session complete (level).
- pass  out  1  signature == GOLDEN; valid only while done=1.
- signature  out  SIG_W  current MISR contents.
- count  out  clog2(N_PATTERNS+1)  captured-pattern count.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, signature=SEED, count=0, busy=0, done=0, pass=0.
  - Reset mid-session aborts with no further captures.
  - Release from reset is synchronous to clk.
- Folding (combinational):
  - fold[j] = XOR of din[k] over all k in 0..DIN_W-1 with k mod SIG_W == j.
- MISR update, applied when state=RUN and en=1, with m = signature[SIG_W-1]:
  - next[0] = m ^ fold[0]
  - next[i] = signature[i-1] ^ fold[i] ^ (POLY[i] & m), for i=1..SIG_W-1
- FSM states:
  - IDLE: busy=0, done=0.
    - start=1 loads signature=SEED, count=0, and goes to RUN on the next edge.
    - din is not captured in the start cycle.
  - RUN: busy=1.
    - Each en=1 cycle updates the MISR and increments count.
    - en=0 holds all state (stall).
    - When count==N_PATTERNS-1 and en=1, that final capture is taken, count becomes N_PATTERNS and the next state is DONE.
    - start is ignored in RUN.
  - DONE: busy=0, done=1.
    - pass is registered on entry as (final signature == GOLDEN).
    - signature and count hold; en is ignored.
    - start=1 clears done/pass, reloads SEED, zeroes count and goes to RUN.
- Timing:
  - The first capture can occur in the cycle after start.
  - done rises on the edge that registers the N_PATTERNS-th capture, so done and the final signature become visible in the same cycle.
- start and en both high in IDLE or DONE: only start takes effect; no capture.
- X on din while not capturing has no effect on state.

Test Plan:
- Use SIG_W=4, DIN_W=8, POLY=4'h3, SEED=0, GOLDEN=4'h3, N_PATTERNS=2 unless a line says otherwise.
- Reset with rst pulsed mid-RUN → busy=0, done=0, signature=4'h0, count=0 immediately (asynchronously, without a clk edge).
- Basic session: start, then en=1 with din=8'h01, then 8'h10 → signature 4'h1 then 4'h3; done=1 and pass=1 in the cycle after the 2nd capture; busy=0.
- Fold aliasing: din=8'h11 then 8'h00 → fold=0 both cycles, signature=4'h0, done=1, pass=0.
- Feedback path (SEED=4'h8, N_PATTERNS=1): start, en=1 with din=0 → signature=4'h3, done=1.
- Stall: basic session with en=0 for 5 cycles between the two captures → same final 4'h3, count stays at 1 during the stall, pass=1.
- Restart and ignore:
  - start during RUN → no effect.
  - start in DONE → done=0, signature=SEED, count=0.
  - The second session reproduces 4'h3 and pass=1.
